seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Reverse direction of the team's BCD-to-seven-segment path.
- Watches a multiplexed (scanned) seven-segment bus: one segment pattern plus a one-hot digit select.
- Filters each digit dwell for stability and decodes the pattern back to BCD.
- Assembles a full NUM_DIGITS frame and hands it downstream on a valid/ready interface; used for display loop-back checking and for reading external panel modules.

Parameters:
NUM_DIGITS, 4, number of scanned digits / width of dig_sel.
STABLE_CYCLES, 4, consecutive identical registered samples required before a digit is captured (min 2).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, synchronous, active-low.
seg_in  input  7  segment levels, active-high, bit6=A, bit5=B, bit4=C, bit3=D, bit2=E, bit1=F, bit0=G.
dig_sel  input  NUM_DIGITS  one-hot digit enable, active-high; bit i = digit i.
bcd_out  output  4*NUM_DIGITS  frame; digit i in bits [4i+3:4i], MSB first (W,X,Y,Z order).
err_out  output  NUM_DIGITS  bit i set = digit i pattern was not a legal code.
out_valid  output  1  frame on bcd_out/err_out is valid.
out_ready  input  1  downstream accepts the frame.
ovf  output  1  sticky: a completed frame was dropped.

Behaviour:
- Input stage: seg_in and dig_sel are registered once (seg_q, sel_q) before any use.
- Decode table (seg_q hex -> BCD):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - Any other pattern -> BCD F with the error bit set.
- Stability counter:
  - If sel_q is one-hot and {seg_q, sel_q} equals the previous cycle's value, the counter increments, saturating at STABLE_CYCLES. Otherwise it loads 1.
  - A non-one-hot sel_q (zero or multi-hot) loads 0 and blocks capture.
  - Capture fires exactly once per dwell: on the cycle the counter transitions to STABLE_CYCLES.
- Capture:
  - Writes the decoded nibble and error bit into shadow slot i, where i is the index of the sel_q bit.
  - Sets collected-mask bit i.
  - Re-capturing a slot before the frame completes overwrites that slot.
- Frame completion: the collected mask becomes all-ones, counting a capture in the same cycle.
- FSM, two states:
  - COLLECT:
    - On completion: load shadow into bcd_out/err_out, out_valid<=1, clear the mask, go to PRESENT.
  - PRESENT:
    - Holds bcd_out/err_out/out_valid stable until out_valid&&out_ready.
    - Collection into the shadow continues in this state.
    - Handshake with no completion: out_valid<=0, go to COLLECT.
    - Completion in the same cycle as the handshake: load the new frame, stay in PRESENT, out_valid remains 1.
    - Completion without a handshake: new frame discarded, mask cleared, ovf<=1.
- Latency: last digit stable at the pins from cycle 0 -> out_valid high in cycle STABLE_CYCLES+1. out_ready has no combinational path to any output.
- Reset (rst_n low at a clock edge):
  - bcd_out=0, err_out=0, out_valid=0, ovf=0.
  - Mask cleared, shadow cleared, counter=0, state COLLECT.
  - A frame pending mid-handshake is dropped.
  - Reset has priority over every other event.

Optional Feature:
- Macro: SEG_BLANK_EN.
- Defined: pattern 00 (all segments off) decodes to BCD F with the error bit clear (legal blank digit, e.g. leading-zero suppression).
- Undefined: 00 is an illegal pattern, giving BCD F with the error bit set.

Test Plan:
- Reset, then scan digits 0..3 with patterns 79,30,7F,7B, each held 6 cycles, out_ready=1 -> out_valid pulses one cycle, bcd_out=16'h9813, err_out=0.
- Glitch: digit 2 pattern alternates 7F/7B every cycle for 3 cycles, then 70 held 5 cycles -> slot 2 captured only as 7, bcd_out[11:8]=7, exactly one capture.
- Illegal pattern 01 on digit 1 plus legal codes elsewhere -> bcd_out[7:4]=F, err_out=4'b0010. Repeat pattern 00 with SEG_BLANK_EN defined -> err_out bit1=0.
- Backpressure: out_ready=0 while two frames complete -> first frame held unchanged on outputs, ovf=1. Raise out_ready -> first frame accepted, out_valid drops next cycle.
- Simultaneous: second frame completes on the same edge as the handshake -> out_valid stays 1, bcd_out updates to the new frame, ovf stays 0.
- dig_sel=4'b0110 or 4'b0000 held 10 cycles -> no capture, mask unchanged. rst_n low during PRESENT -> out_valid=0 at the next edge.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Scanned seven-segment bus to BCD frame decoder with per-digit stability filtering.
// Build option: define SEG_BLANK_EN to accept the all-off pattern as a legal blank digit.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     err_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      ovf
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {S_COLLECT, S_PRESENT} state_t;

    logic [6:0]                r_seg_q, r_prev_seg;
    logic [NUM_DIGITS-1:0]     r_sel_q, r_prev_sel;
    logic [CW-1:0]             r_cnt;
    logic [4*NUM_DIGITS-1:0]   r_shadow_bcd, r_bcd;
    logic [NUM_DIGITS-1:0]     r_shadow_err, r_err, r_mask;
    logic                      r_valid, r_ovf;
    state_t                    r_state;

    logic [3:0]                w_nib;
    logic                      w_bad, w_onehot, w_same, w_capture, w_complete;
    logic [CW-1:0]             w_cnt_nxt;
    logic [4*NUM_DIGITS-1:0]   w_shadow_bcd_nxt, w_bcd_nxt;
    logic [NUM_DIGITS-1:0]     w_shadow_err_nxt, w_err_nxt, w_mask_cap, w_mask_nxt;
    logic                      w_valid_nxt, w_ovf_nxt;
    state_t                    w_state_nxt;

    always_comb begin
        w_nib = 4'hF;
        w_bad = 1'b1;
        case (r_seg_q)
            7'h7E: begin w_nib = 4'd0; w_bad = 1'b0; end
            7'h30: begin w_nib = 4'd1; w_bad = 1'b0; end
            7'h6D: begin w_nib = 4'd2; w_bad = 1'b0; end
            7'h79: begin w_nib = 4'd3; w_bad = 1'b0; end
            7'h33: begin w_nib = 4'd4; w_bad = 1'b0; end
            7'h5B: begin w_nib = 4'd5; w_bad = 1'b0; end
            7'h5F: begin w_nib = 4'd6; w_bad = 1'b0; end
            7'h70: begin w_nib = 4'd7; w_bad = 1'b0; end
            7'h7F: begin w_nib = 4'd8; w_bad = 1'b0; end
            7'h7B: begin w_nib = 4'd9; w_bad = 1'b0; end
`ifdef SEG_BLANK_EN
            7'h00: begin w_nib = 4'hF; w_bad = 1'b0; end
`endif
            default: begin w_nib = 4'hF; w_bad = 1'b1; end
        endcase
    end

    // Capture fires only on the transition into the saturated count, so once per dwell.
    always_comb begin
        w_onehot  = (r_sel_q != '0) && ((r_sel_q & (r_sel_q - NUM_DIGITS'(1))) == '0);
        w_same    = ({r_seg_q, r_sel_q} == {r_prev_seg, r_prev_sel});
        w_capture = w_onehot && w_same && (r_cnt == CW'(STABLE_CYCLES - 1));
        if (!w_onehot)
            w_cnt_nxt = '0;
        else if (!w_same)
            w_cnt_nxt = CW'(1);
        else if (r_cnt == CW'(STABLE_CYCLES))
            w_cnt_nxt = r_cnt;
        else
            w_cnt_nxt = r_cnt + CW'(1);
    end

    always_comb begin
        w_shadow_bcd_nxt = r_shadow_bcd;
        w_shadow_err_nxt = r_shadow_err;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_capture && r_sel_q[i]) begin
                w_shadow_bcd_nxt[4*i +: 4] = w_nib;
                w_shadow_err_nxt[i]        = w_bad;
            end
        end
        w_mask_cap = r_mask | (w_capture ? r_sel_q : '0);
        w_complete = &w_mask_cap;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_err_nxt   = r_err;
        w_valid_nxt = r_valid;
        w_ovf_nxt   = r_ovf;
        w_mask_nxt  = w_mask_cap;
        case (r_state)
            S_COLLECT: begin
                if (w_complete) begin
                    w_bcd_nxt   = w_shadow_bcd_nxt;
                    w_err_nxt   = w_shadow_err_nxt;
                    w_valid_nxt = 1'b1;
                    w_mask_nxt  = '0;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (r_valid && out_ready) begin
                    if (w_complete) begin
                        w_bcd_nxt  = w_shadow_bcd_nxt;
                        w_err_nxt  = w_shadow_err_nxt;
                        w_mask_nxt = '0;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_COLLECT;
                    end
                end else if (w_complete) begin
                    // Downstream still holds the previous frame: drop the new one.
                    w_mask_nxt = '0;
                    w_ovf_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_q      <= '0;
            r_sel_q      <= '0;
            r_prev_seg   <= '0;
            r_prev_sel   <= '0;
            r_cnt        <= '0;
            r_shadow_bcd <= '0;
            r_shadow_err <= '0;
            r_mask       <= '0;
            r_bcd        <= '0;
            r_err        <= '0;
            r_valid      <= 1'b0;
            r_ovf        <= 1'b0;
            r_state      <= S_COLLECT;
        end else begin
            r_seg_q      <= seg_in;
            r_sel_q      <= dig_sel;
            r_prev_seg   <= r_seg_q;
            r_prev_sel   <= r_sel_q;
            r_cnt        <= w_cnt_nxt;
            r_shadow_bcd <= w_shadow_bcd_nxt;
            r_shadow_err <= w_shadow_err_nxt;
            r_mask       <= w_mask_nxt;
            r_bcd        <= w_bcd_nxt;
            r_err        <= w_err_nxt;
            r_valid      <= w_valid_nxt;
            r_ovf        <= w_ovf_nxt;
            r_state      <= w_state_nxt;
        end
    end

    assign bcd_out   = r_bcd;
    assign err_out   = r_err;
    assign out_valid = r_valid;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: expected frames are queued by the stimulus
// and popped by a monitor on every out_valid/out_ready handshake.
module tb_seg_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] dig_sel;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] err_out;
    logic          out_valid;
    logic          out_ready;
    logic          ovf;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  err;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;
    int     n_pass  = 0;
    int     n_total = 0;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
        .bcd_out(bcd_out), .err_out(err_out), .out_valid(out_valid),
        .out_ready(out_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dig(input int d, input logic [6:0] p, input int n);
        seg_in  = p;
        dig_sel = 4'(1 << d);
        tick(n);
    endtask

    task automatic frame4(input logic [6:0] p0, input logic [6:0] p1,
                          input logic [6:0] p2, input logic [6:0] p3);
        dig(0, p0, 6);
        dig(1, p1, 6);
        dig(2, p2, 6);
        dig(3, p3, 6);
    endtask

    task automatic push(input logic [15:0] b, input logic [3:0] e);
        frame_t f;
        f.bcd = b;
        f.err = e;
        exp_q.push_back(f);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_frame: got bcd %h err %b, expected no frame", bcd_out, err_out);
            end else begin
                mon_f = exp_q.pop_front();
                chk("frame_bcd", 32'(bcd_out), 32'(mon_f.bcd));
                chk("frame_err", 32'(err_out), 32'(mon_f.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic saw_valid;
        rst_n = 1'b0; seg_in = '0; dig_sel = '0; out_ready = 1'b0;
        tick(2);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Basic frame with immediate acceptance
        out_ready = 1'b1;
        push(16'h9813, 4'b0000);
        frame4(7'h79, 7'h30, 7'h7F, 7'h7B);
        drain("drain_basic");
        tick(2);
        chk("basic_pulse_done", 32'(out_valid), 32'd0);

        // Glitching digit 2 must only capture the final stable 7
        push(16'h4710, 4'b0000);
        dig(0, 7'h7E, 6);
        dig(1, 7'h30, 6);
        dig(2, 7'h7F, 1);
        dig(2, 7'h7B, 1);
        dig(2, 7'h7F, 1);
        dig(2, 7'h70, 5);
        dig(3, 7'h33, 6);
        drain("drain_glitch");

        // Illegal and blank patterns on digit 1
        push(16'h76F5, 4'b0010);
        frame4(7'h5B, 7'h01, 7'h5F, 7'h70);
        drain("drain_illegal");
`ifdef SEG_BLANK_EN
        push(16'h76F5, 4'b0000);
`else
        push(16'h76F5, 4'b0010);
`endif
        frame4(7'h5B, 7'h00, 7'h5F, 7'h70);
        drain("drain_blank");

        // Backpressure: second frame dropped, first held
        out_ready = 1'b0;
        push(16'h5432, 4'b0000);
        frame4(7'h6D, 7'h79, 7'h33, 7'h5B);
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        frame4(7'h7F, 7'h70, 7'h5F, 7'h5B);
        dig_sel = '0;
        chk("bp_held_bcd", 32'(bcd_out), 32'h5432);
        chk("bp_held_valid", 32'(out_valid), 32'd1);
        chk("bp_ovf", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        tick(1);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        drain("drain_bp");

        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Completion on the same edge as the handshake
        out_ready = 1'b0;
        push(16'h4321, 4'b0000);
        push(16'h9876, 4'b0000);
        frame4(7'h30, 7'h6D, 7'h79, 7'h33);
        dig(0, 7'h5F, 6);
        dig(1, 7'h70, 6);
        dig(2, 7'h7F, 6);
        dig(3, 7'h7B, 4);
        chk("sim_pre_bcd", 32'(bcd_out), 32'h4321);
        out_ready = 1'b1;
        tick(1);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_bcd", 32'(bcd_out), 32'h9876);
        chk("sim_ovf", 32'(ovf), 32'd0);
        dig_sel = '0;
        drain("drain_sim");
        tick(1);
        chk("sim_valid_drop", 32'(out_valid), 32'd0);

        // Non-one-hot selects must not capture
        push(16'h3540, 4'b0000);
        dig(0, 7'h7E, 6);
        dig(1, 7'h33, 6);
        dig(2, 7'h5B, 6);
        saw_valid = 1'b0;
        seg_in = 7'h7E;
        dig_sel = 4'b0110;
        for (int i = 0; i < 10; i++) begin tick(1); saw_valid |= out_valid; end
        dig_sel = 4'b0000;
        for (int i = 0; i < 10; i++) begin tick(1); saw_valid |= out_valid; end
        chk("no_capture_nonhot", 32'(saw_valid), 32'd0);
        dig(3, 7'h79, 6);
        drain("drain_nonhot");

        // Reset while presenting drops the pending frame
        out_ready = 1'b0;
        frame4(7'h7E, 7'h7E, 7'h7E, 7'h7E);
        chk("pres_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick(1);
        chk("prst_valid", 32'(out_valid), 32'd0);
        chk("prst_bcd", 32'(bcd_out), 32'd0);
        chk("prst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        dig_sel = '0;
        out_ready = 1'b1;
        tick(5);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
